data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Multi-cycle data-memory responder on the far side of the pipeline's MEM-stage load/store request interface. It accepts one request at a time from the pipeline's MEM stage and holds BUSY so the pipeline stalls. It services RV32 byte, halfword and word loads and stores, with sign or zero extension selected by FUNC3. Storage is an internal word array.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; must be a power of 2. ADDR_W = log2(DEPTH_WORDS).
LATENCY, 3, cycles BUSY stays high per request; must be ≥1.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
MEM_READ  in  1  load request
MEM_WRITE  in  1  store request
ADDR  in  32  byte address
WRITE_DATA  in  32  store data; value taken from low bits
FUNC3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
READ_DATA  out  32  load result, extended; valid in DONE cycle only
BUSY  out  1  stall request to pipeline
MISALIGNED  out  1  1-cycle pulse in DONE for an illegal access

Behaviour:
- Reset (RST=0, async): state=IDLE, READ_DATA=0, MISALIGNED=0, latency counter=0. BUSY=0. Array contents are not cleared.
- Request valid (req) = MEM_READ | MEM_WRITE. Requester holds ADDR, FUNC3, WRITE_DATA and the request bits stable while BUSY=1.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on req, latch the request, load counter=LATENCY-1 and go to WAIT. BUSY is combinationally 1 in this cycle.
  - WAIT: BUSY=1. Decrement the counter. When the counter reaches 0, perform the array access on that edge and go to DONE.
  - DONE: BUSY=0. READ_DATA holds the load result. MISALIGNED is valid. Unconditionally go to IDLE next cycle.
- BUSY = (state==IDLE & req) | (state==WAIT). With a request in cycle 0, BUSY is 1 for cycles 0..LATENCY-1 and DONE falls in cycle LATENCY.
- A request still asserted in the cycle after DONE is treated as a new request and gets full latency.
- Word index = latched ADDR[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Loads: select byte lane ADDR[1:0] or half lane ADDR[1]. b and h sign-extend; bu and hu zero-extend; w passes through.
- Stores: sb writes WRITE_DATA[7:0] into lane ADDR[1:0]. sh writes WRITE_DATA[15:0] into lane ADDR[1]. sw writes the whole word. Other lanes are preserved.
- Misaligned cases: h/hu/sh with ADDR[0]=1, or w/sw with ADDR[1:0]≠0.
  - The array is not modified.
  - READ_DATA=0 and MISALIGNED=1 in DONE.
- MEM_READ and MEM_WRITE both high: treated as a store, and READ_DATA=0 in DONE.
- Illegal FUNC3 (011, 110, 111): treated as misaligned (no access, MISALIGNED=1).
- READ_DATA is 0 in DONE after a store. Outside DONE it holds its last value.
- Reset during WAIT aborts the access with no array write. The request must be reissued and receives full latency.

Optional Feature:
DMEM_STATS_EN:
- Defined: adds outputs LOAD_COUNT[31:0] and STORE_COUNT[31:0]. Each increments on entry to DONE for a completed, non-misaligned load or store. Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rv32_mem_pkg holds:
  - FUNC3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state typedef (IDLE/WAIT/DONE);
  - the misalign-check function.
- Sub-module dmem_lane_align: combinational load extract/extend and store lane merge (old word, data, ADDR[1:0], FUNC3 → new word, load value).
- The top holds the FSM, counter, array and optional stats.

Test Plan:
- Word round trip, LATENCY=3: sw 0xDEADBEEF @0x10, then lw @0x10 → BUSY high exactly 3 cycles each; DONE READ_DATA=0xDEADBEEF.
- Byte store/load extension: sb 0x80 @0x11 over 0x00000000 → word=0x00008000. lb @0x11 → 0xFFFFFF80; lbu → 0x00000080.
- Halfword: sh 0xF00D @0x22 over 0x11223344 → 0xF00D3344. lh @0x22 → 0xFFFFF00D; lhu → 0x0000F00D.
- Misaligned and wrap:
  - lw @0x13 → MISALIGNED pulse, READ_DATA=0, no change to the array.
  - sw 0xA5A5A5A5 @(DEPTH_WORDS*4) → lw @0x0 returns 0xA5A5A5A5.
- Reset in WAIT: assert RST=0 mid-sw @0x40 (old value 0x12345678) → BUSY drops immediately. After release, lw @0x40 → 0x12345678.
- Back-to-back requests and stats (DMEM_STATS_EN): request held after DONE → second full 3-cycle BUSY. LOAD_COUNT/STORE_COUNT match the count of completed aligned ops; a misaligned op is not counted.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the data-memory responder: FUNC3 encodings,
// responder FSM states and the access-legality check.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Unknown FUNC3 encodings are reported the same way as a misaligned access.
  function automatic logic misalign_check(input logic [2:0] func3,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (func3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane handling: extracts and extends a load value from a word
// and merges store data into a word. Legality is decided by the caller.
module dmem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] new_word,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = old_word[7:0];
      2'd1: byte_sel = old_word[15:8];
      2'd2: byte_sel = old_word[23:16];
      2'd3: byte_sel = old_word[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];
  end

  always_comb begin
    load_val = old_word;
    case (func3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h000000, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0000, half_sel};
      default: load_val = old_word;
    endcase
  end

  // Store width comes from the low two FUNC3 bits (byte, half, word).
  always_comb begin
    new_word = old_word;
    case (func3[1:0])
      2'b00: begin
        case (addr_lo)
          2'd0: new_word[7:0]   = wdata[7:0];
          2'd1: new_word[15:8]  = wdata[7:0];
          2'd2: new_word[23:16] = wdata[7:0];
          2'd3: new_word[31:24] = wdata[7:0];
          default: new_word = old_word;
        endcase
      end
      2'b01: begin
        if (addr_lo[1]) new_word[31:16] = wdata[15:0];
        else            new_word[15:0]  = wdata[15:0];
      end
      2'b10:   new_word = wdata;
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle RV32 data-memory responder: one request at a time, BUSY stalls
// the pipeline for LATENCY cycles. Define DMEM_STATS_EN for load/store counters.
module data_mem_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [2:0]  func3,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        misaligned
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count
`endif
);

  localparam int   ADDR_W = $clog2(DEPTH_WORDS);
  localparam int   CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic SINGLE = (LATENCY == 1);

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              l_read, l_write;
  logic [ADDR_W+1:0] l_addr;
  logic [2:0]        l_func3;
  logic [31:0]       l_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic              req, in_idle, access, mem_we;
  logic              cur_read, cur_write, cur_mis;
  logic [ADDR_W+1:0] cur_addr;
  logic [2:0]        cur_func3;
  logic [31:0]       cur_wdata, old_word, new_word, load_val;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req     = mem_read | mem_write;
  assign in_idle = (state == IDLE);
  assign busy    = rst & ((in_idle & req) | (state == WAIT));

  // With LATENCY==1 the access happens on the accepting edge, straight from the inputs.
  assign cur_read  = in_idle ? mem_read           : l_read;
  assign cur_write = in_idle ? mem_write          : l_write;
  assign cur_addr  = in_idle ? addr[ADDR_W+1:0]   : l_addr;
  assign cur_func3 = in_idle ? func3              : l_func3;
  assign cur_wdata = in_idle ? write_data         : l_wdata;

  assign cur_mis  = misalign_check(cur_func3, cur_addr[1:0]);
  assign access   = ((state == WAIT) && (cnt == CNT_W'(1))) || (in_idle && req && SINGLE);
  assign mem_we   = access & cur_write & ~cur_mis;
  assign old_word = mem[cur_addr[ADDR_W+1:2]];

  dmem_lane_align u_align (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .addr_lo  (cur_addr[1:0]),
    .func3    (cur_func3),
    .new_word (new_word),
    .load_val (load_val)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_addr[ADDR_W+1:2]] <= new_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      read_data  <= '0;
      misaligned <= 1'b0;
      l_read     <= 1'b0;
      l_write    <= 1'b0;
      l_addr     <= '0;
      l_func3    <= '0;
      l_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            l_read  <= mem_read;
            l_write <= mem_write;
            l_addr  <= addr[ADDR_W+1:0];
            l_func3 <= func3;
            l_wdata <= write_data;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= SINGLE ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Stores, simultaneous read+write and illegal accesses all return zero.
      if (access) begin
        read_data  <= (cur_read & ~cur_write & ~cur_mis) ? load_val : 32'h0;
        misaligned <= cur_mis;
      end else if (state == DONE) begin
        misaligned <= 1'b0;
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (access && !cur_mis) begin
      if (cur_write)     store_count <= store_count + 32'd1;
      else if (cur_read) load_count  <= load_count + 32'd1;
    end
  end
`endif

endmodule
